// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Writeback stage in front of the integer register file.
//               Buffers results from NR_SRC functional units in per-source
//               FIFOs and retires up to NR_WRITE_PORTS of them per cycle
//               with round-robin arbitration. Two ports never target the
//               same register in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int NR_SRC         = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int FIFO_DEPTH     = 2,
    parameter bit ZERO_REG_ZERO  = 1'b1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      stall_i,
    input  logic [NR_SRC-1:0]                         src_valid_i,
    output logic [NR_SRC-1:0]                         src_ready_o,
    input  logic [NR_SRC-1:0][4:0]                    src_addr_i,
    input  logic [NR_SRC-1:0][DATA_WIDTH-1:0]         src_data_i,
    output logic [NR_WRITE_PORTS-1:0]                 we_o,
    output logic [NR_WRITE_PORTS-1:0][4:0]            waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_o,
    output logic [31:0]                               pending_o,
    output logic                                      busy_o
);

    localparam int c_src_w = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_gnt_w = $clog2(NR_WRITE_PORTS + 1);

    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);
    localparam logic [c_gnt_w-1:0] c_nr_ports = c_gnt_w'(NR_WRITE_PORTS);
    localparam logic [c_src_w:0]   c_nr_src   = (c_src_w + 1)'(NR_SRC);
    localparam logic [c_src_w-1:0] c_last_src = c_src_w'(NR_SRC - 1);

    // Per-source FIFO views
    logic [NR_SRC-1:0]                 w_push;
    logic [NR_SRC-1:0]                 w_pop;
    logic [NR_SRC-1:0]                 w_nonempty;
    logic [NR_SRC-1:0][4:0]            w_head_addr;
    logic [NR_SRC-1:0][DATA_WIDTH-1:0] w_head_data;
    logic [NR_SRC-1:0][31:0]           w_src_pend;

    // Arbitration results
    logic [NR_WRITE_PORTS-1:0]                 w_gnt_vld;
    logic [NR_WRITE_PORTS-1:0][4:0]            w_gnt_addr;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] w_gnt_data;
    logic [c_gnt_w-1:0]                        w_ngnt;
    logic [c_src_w-1:0]                        w_last_src;
    logic [c_src_w:0]                          w_scan;
    logic [c_src_w-1:0]                        w_idx;
    logic                                      w_hit;

    logic [c_src_w-1:0] r_rr;

    for (genvar s = 0; s < NR_SRC; s++) begin : g_src
        logic [4:0]            r_addr [FIFO_DEPTH];
        logic [DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
        logic [FIFO_DEPTH-1:0] r_vld;
        logic [c_ptr_w-1:0]    r_rd_ptr;
        logic [c_ptr_w-1:0]    r_wr_ptr;
        logic [c_cnt_w-1:0]    r_count;
        logic [31:0]           w_pend;

        // Ready depends only on occupancy, never on this cycle's pop
        assign src_ready_o[s] = rst_ni && (r_count != c_depth);
        assign w_push[s]      = src_valid_i[s] && src_ready_o[s];
        assign w_nonempty[s]  = (r_count != '0);
        assign w_head_addr[s] = r_addr[r_rd_ptr];
        assign w_head_data[s] = r_data[r_rd_ptr];
        assign w_src_pend[s]  = w_pend;

        // Pointer, occupancy and slot-valid bookkeeping
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_vld    <= '0;
            end else begin
                if (w_push[s]) begin
                    r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
                    r_vld[r_wr_ptr] <= 1'b1;
                end
                if (w_pop[s]) begin
                    r_rd_ptr        <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
                    r_vld[r_rd_ptr] <= 1'b0;
                end
                r_count <= r_count + c_cnt_w'(w_push[s]) - c_cnt_w'(w_pop[s]);
            end
        end

        // Payload storage; contents are qualified by r_vld so no reset needed
        always_ff @(posedge clk_i) begin
            if (w_push[s]) begin
                r_addr[r_wr_ptr] <= src_addr_i[s];
                r_data[r_wr_ptr] <= src_data_i[s];
            end
        end

        // Registers targeted by any buffered entry of this source
        always_comb begin
            w_pend = '0;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                if (r_vld[j]) begin
                    w_pend[r_addr[j]] = 1'b1;
                end
            end
        end
    end

    // Round-robin scan of FIFO heads, skipping same-register collisions
    always_comb begin
        w_pop      = '0;
        w_gnt_vld  = '0;
        w_gnt_addr = '0;
        w_gnt_data = '0;
        w_ngnt     = '0;
        w_last_src = '0;
        w_scan     = '0;
        w_idx      = '0;
        w_hit      = 1'b0;
        for (int i = 0; i < NR_SRC; i++) begin
            w_scan = {1'b0, r_rr} + (c_src_w + 1)'(i);
            if (w_scan >= c_nr_src) begin
                w_scan = w_scan - c_nr_src;
            end
            w_idx = w_scan[c_src_w-1:0];
            w_hit = 1'b0;
            for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                if (w_gnt_vld[k] && (w_gnt_addr[k] == w_head_addr[w_idx])) begin
                    w_hit = 1'b1;
                end
            end
            if (rst_ni && !stall_i && w_nonempty[w_idx] && !w_hit && (w_ngnt < c_nr_ports)) begin
                w_pop[w_idx] = 1'b1;
                for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                    if (c_gnt_w'(k) == w_ngnt) begin
                        w_gnt_vld[k]  = 1'b1;
                        w_gnt_addr[k] = w_head_addr[w_idx];
                        w_gnt_data[k] = w_head_data[w_idx];
                    end
                end
                w_ngnt     = w_ngnt + 1'b1;
                w_last_src = w_idx;
            end
        end
    end

    // Round-robin pointer moves past the last granted source
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr <= '0;
        end else if (w_ngnt != '0) begin
            r_rr <= (w_last_src == c_last_src) ? '0 : w_last_src + 1'b1;
        end
    end

    // A granted x0 write still consumes its port slot but is not enabled
    for (genvar k = 0; k < NR_WRITE_PORTS; k++) begin : g_port
        assign we_o[k] = w_gnt_vld[k] && !(ZERO_REG_ZERO && (w_gnt_addr[k] == 5'd0));
    end
    assign waddr_o = w_gnt_addr;
    assign wdata_o = w_gnt_data;

    // Pending scoreboard and busy flag, forced low during reset
    always_comb begin
        pending_o = '0;
        if (rst_ni) begin
            for (int s = 0; s < NR_SRC; s++) begin
                pending_o = pending_o | w_src_pend[s];
            end
        end
        if (ZERO_REG_ZERO) begin
            pending_o[0] = 1'b0;
        end
    end

    assign busy_o = rst_ni && (|w_nonempty);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed vector bench for regfile_wb_arbiter (default
//               parameters) plus a back-to-back streaming sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              stall_i;
    logic [3:0]        src_valid_i;
    logic [3:0]        src_ready_o;
    logic [3:0][4:0]   src_addr_i;
    logic [3:0][63:0]  src_data_i;
    logic [1:0]        we_o;
    logic [1:0][4:0]   waddr_o;
    logic [1:0][63:0]  wdata_o;
    logic [31:0]       pending_o;
    logic              busy_o;

    always #5 clk_i = ~clk_i;

    regfile_wb_arbiter #(
        .DATA_WIDTH     (64),
        .NR_SRC         (4),
        .NR_WRITE_PORTS (2),
        .FIFO_DEPTH     (2),
        .ZERO_REG_ZERO  (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .stall_i     (stall_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_addr_i  (src_addr_i),
        .src_data_i  (src_data_i),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .pending_o   (pending_o),
        .busy_o      (busy_o)
    );

    // Register file model fed by the write ports
    logic [63:0] rf [32];
    always @(posedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (we_o[k]) rf[waddr_o[k]] <= wdata_o[k];
        end
    end

    // Captures writes to x20 during the streaming sequence
    logic        mon_en = 1'b0;
    logic [63:0] mon_q [$];
    always @(posedge clk_i) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (we_o[k] && (waddr_o[k] == 5'd20)) mon_q.push_back(wdata_o[k]);
            end
        end
    end

    typedef struct {
        logic             rst_n;
        logic             stall;
        logic [3:0]       valid;
        logic [3:0][4:0]  addr;
        logic [3:0][63:0] data;
        logic [3:0]       e_ready;
        logic [1:0]       e_we;
        logic [1:0][4:0]  e_waddr;
        logic [1:0][63:0] e_wdata;
        logic [31:0]      e_pend;
        logic             e_busy;
    } vec_t;

    vec_t vecs [$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rn, input logic st, input logic [3:0] va,
                       input logic [3:0][4:0] ad, input logic [3:0][63:0] da,
                       input logic [3:0] er, input logic [1:0] ew,
                       input logic [1:0][4:0] ea, input logic [1:0][63:0] ed,
                       input logic [31:0] ep, input logic eb);
        vec_t v;
        v.rst_n = rn; v.stall = st; v.valid = va; v.addr = ad; v.data = da;
        v.e_ready = er; v.e_we = ew; v.e_waddr = ea; v.e_wdata = ed;
        v.e_pend = ep; v.e_busy = eb;
        vecs.push_back(v);
    endtask

    initial begin
        logic [63:0] sval;
        logic        acc;
        int          guard;
        logic [3:0][4:0]  a_fill;
        logic [3:0][63:0] d_fill;

        a_fill = {5'd13, 5'd12, 5'd11, 5'd10};
        d_fill = {64'hE3, 64'hE2, 64'hE1, 64'hE0};

        // Reset and idle
        add(0, 0, 4'h0, '0, '0, 4'h0, 2'b00, '0, '0, 32'h0, 0);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        // Single push, one-cycle retire
        add(1, 0, 4'h1, {15'd0, 5'd5}, {192'd0, 64'hA5}, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b01, {5'd0, 5'd5}, {64'd0, 64'hA5}, 32'h20, 1);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        // Reset to bring rr back to 0, then four sources under stall
        add(0, 0, 4'h0, '0, '0, 4'h0, 2'b00, '0, '0, 32'h0, 0);
        add(1, 1, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1}, {64'hD4, 64'hD3, 64'hD2, 64'hD1},
            4'hF, 2'b00, '0, '0, 32'h0, 0);
        add(1, 1, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h1E, 1);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b11, {5'd2, 5'd1}, {64'hD2, 64'hD1}, 32'h1E, 1);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b11, {5'd4, 5'd3}, {64'hD4, 64'hD3}, 32'h18, 1);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        // Same-register collision between src0 and src1
        add(1, 0, 4'h3, {10'd0, 5'd7, 5'd7}, {128'd0, 64'h22, 64'h11}, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b01, {5'd0, 5'd7}, {64'd0, 64'h11}, 32'h80, 1);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b01, {5'd0, 5'd7}, {64'd0, 64'h22}, 32'h80, 1);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        // Full FIFO back-pressure on src0 (rr=2 here)
        add(1, 1, 4'h1, {15'd0, 5'd9}, {192'd0, 64'h1}, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        add(1, 1, 4'h1, {15'd0, 5'd9}, {192'd0, 64'h2}, 4'hF, 2'b00, '0, '0, 32'h200, 1);
        add(1, 1, 4'h1, {15'd0, 5'd9}, {192'd0, 64'h3}, 4'hE, 2'b00, '0, '0, 32'h200, 1);
        add(1, 0, 4'h1, {15'd0, 5'd9}, {192'd0, 64'h3}, 4'hE, 2'b01, {5'd0, 5'd9}, {64'd0, 64'h1}, 32'h200, 1);
        add(1, 0, 4'h1, {15'd0, 5'd9}, {192'd0, 64'h3}, 4'hF, 2'b01, {5'd0, 5'd9}, {64'd0, 64'h2}, 32'h200, 1);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b01, {5'd0, 5'd9}, {64'd0, 64'h3}, 32'h200, 1);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        // Write to x0 is consumed without enabling a port
        add(1, 0, 4'h4, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 1);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        // Fill everything under stall, then reset mid-operation
        add(1, 1, 4'hF, a_fill, d_fill, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        add(1, 1, 4'hF, a_fill, d_fill, 4'hF, 2'b00, '0, '0, 32'h3C00, 1);
        add(1, 1, 4'hF, a_fill, d_fill, 4'h0, 2'b00, '0, '0, 32'h3C00, 1);
        add(0, 0, 4'hF, a_fill, d_fill, 4'h0, 2'b00, '0, '0, 32'h0, 0);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 0);
        add(1, 0, 4'h0, '0, '0, 4'hF, 2'b00, '0, '0, 32'h0, 0);

        rst_ni = 1'b0; stall_i = 1'b0; src_valid_i = '0; src_addr_i = '0; src_data_i = '0;
        @(posedge clk_i); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_ni      = vecs[i].rst_n;
            stall_i     = vecs[i].stall;
            src_valid_i = vecs[i].valid;
            src_addr_i  = vecs[i].addr;
            src_data_i  = vecs[i].data;
            #3;
            checks++;
            if (src_ready_o !== vecs[i].e_ready || we_o !== vecs[i].e_we ||
                waddr_o !== vecs[i].e_waddr || wdata_o !== vecs[i].e_wdata ||
                pending_o !== vecs[i].e_pend || busy_o !== vecs[i].e_busy) begin
                errors++;
                $display("FAIL row%0d: got ready=%h we=%b waddr=%h wdata=%h pend=%h busy=%b; want ready=%h we=%b waddr=%h wdata=%h pend=%h busy=%b",
                         i, src_ready_o, we_o, waddr_o, wdata_o, pending_o, busy_o,
                         vecs[i].e_ready, vecs[i].e_we, vecs[i].e_waddr, vecs[i].e_wdata,
                         vecs[i].e_pend, vecs[i].e_busy);
            end
            @(posedge clk_i); #1;
        end

        // Collision: the later source's value must land last
        checks++;
        if (rf[7] !== 64'h22) begin
            errors++;
            $display("FAIL x7_final: got %h want %h", rf[7], 64'h22);
        end

        // Streaming: src1 pushes 1..4 to x20 back-to-back without stall
        src_valid_i = '0; src_addr_i = '0; src_data_i = '0; stall_i = 1'b0;
        mon_en = 1'b1;
        sval   = 64'd1;
        guard  = 0;
        while (sval <= 64'd4 && guard < 30) begin
            src_valid_i   = 4'b0010;
            src_addr_i[1] = 5'd20;
            src_data_i[1] = sval;
            #1;
            acc = src_ready_o[1];
            @(posedge clk_i); #1;
            guard++;
            if (acc) sval = sval + 64'd1;
        end
        src_valid_i = '0;
        checks++;
        if (sval <= 64'd4) begin
            errors++;
            $display("FAIL stream_accept: accepted %0d want 4", sval - 64'd1);
        end
        guard = 0;
        while (busy_o && guard < 20) begin
            @(posedge clk_i); #1;
            guard++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: busy=%b want 0", busy_o);
        end
        mon_en = 1'b0;
        checks++;
        if (mon_q.size() != 4) begin
            errors++;
            $display("FAIL stream_count: got %0d writes want 4", mon_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mon_q[i] !== 64'(i + 1)) begin
                    errors++;
                    $display("FAIL stream_order%0d: got %h want %h", i, mon_q[i], 64'(i + 1));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
